// File: rtl/mem_io_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_io_arb_pkg : shared types and helpers for the memory/IO arbiter |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mem_io_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUS  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_DBG = 1'b1
  } arb_src_t;

  localparam int ARB_WAIT_MAX_DEFAULT = 15;

  // Winner of the request pair; only meaningful when at least one req is high.
  function automatic arb_src_t arb_pick(input logic cpu_req, input logic dbg_req,
                                        input logic prio_dbg, input arb_src_t rr_last);
    arb_src_t win;
    if (cpu_req && dbg_req) begin
      if (prio_dbg) win = SRC_DBG;
      else          win = (rr_last == SRC_CPU) ? SRC_DBG : SRC_CPU;
    end else if (dbg_req) begin
      win = SRC_DBG;
    end else begin
      win = SRC_CPU;
    end
    return win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_io_arb_wait_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arb_wait_timer : 8-bit saturating wait-state counter, terminal flag |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module arb_wait_timer
  import mem_io_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       term
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 8'd0;
    end else if (en && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 8'd0;
    else        count_q <= count_d;
  end

  assign term = (count_q == (limit - 8'd1));

endmodule
`default_nettype wire

// File: rtl/mem_io_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_io_arb : CPU / debug-port arbiter for the shared memory/IO bus  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mem_io_arb
  import mem_io_arb_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int WAIT_MAX = ARB_WAIT_MAX_DEFAULT,
  parameter int PRIO_DBG = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_iom,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic          cpu_err,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic          dbg_iom,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic          dbg_err,
  output logic [DW-1:0] dbg_rdata,
  output logic          bus_valid,
  output logic          bus_we,
  output logic          bus_iom,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ready,
  input  logic [DW-1:0] bus_rdata,
  output logic          busy
);

  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);
  localparam logic       PRIO_BIT   = (PRIO_DBG != 0);

  arb_state_t    state_q, state_d;
  arb_src_t      src_q, src_d;
  arb_src_t      rr_last_q, rr_last_d;
  arb_src_t      win;
  logic          bus_valid_q, bus_valid_d;
  logic          bus_we_q, bus_we_d;
  logic          bus_iom_q, bus_iom_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic          cpu_ack_q, cpu_ack_d, cpu_err_q, cpu_err_d;
  logic          dbg_ack_q, dbg_ack_d, dbg_err_q, dbg_err_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic          busy_q, busy_d;
  logic          wait_term;

  // Counter sits at zero on the first ARB_BUS cycle and counts unanswered cycles.
  arb_wait_timer u_wait_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != ARB_BUS),
    .en    ((state_q == ARB_BUS) && !bus_ready),
    .limit (WAIT_LIMIT),
    .term  (wait_term)
  );

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    rr_last_d   = rr_last_q;
    win         = arb_pick(cpu_req, dbg_req, PRIO_BIT, rr_last_q);
    bus_valid_d = bus_valid_q;
    bus_we_d    = bus_we_q;
    bus_iom_d   = bus_iom_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    cpu_ack_d   = 1'b0;
    cpu_err_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    dbg_err_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    case (state_q)
      ARB_IDLE: begin
        if (cpu_req || dbg_req) begin
          src_d       = win;
          rr_last_d   = win;
          bus_valid_d = 1'b1;
          state_d     = ARB_BUS;
          if (win == SRC_DBG) begin
            bus_we_d    = dbg_we;
            bus_iom_d   = dbg_iom;
            bus_addr_d  = dbg_addr;
            bus_wdata_d = dbg_wdata;
          end else begin
            bus_we_d    = cpu_we;
            bus_iom_d   = cpu_iom;
            bus_addr_d  = cpu_addr;
            bus_wdata_d = cpu_wdata;
          end
        end
      end
      ARB_BUS: begin
        if (bus_ready || wait_term) begin
          bus_valid_d = 1'b0;
          state_d     = ARB_RESP;
          if (src_q == SRC_CPU) begin
            cpu_ack_d = 1'b1;
            cpu_err_d = !bus_ready;
            if (bus_ready && !bus_we_q) cpu_rdata_d = bus_rdata;
          end else begin
            dbg_ack_d = 1'b1;
            dbg_err_d = !bus_ready;
            if (bus_ready && !bus_we_q) dbg_rdata_d = bus_rdata;
          end
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      src_q       <= SRC_CPU;
      rr_last_q   <= SRC_DBG;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_iom_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      dbg_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      rr_last_q   <= rr_last_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_iom_q   <= bus_iom_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_err_q   <= cpu_err_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_err_q   <= dbg_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_err   = cpu_err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_ack   = dbg_ack_q;
  assign dbg_err   = dbg_err_q;
  assign dbg_rdata = dbg_rdata_q;
  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_iom   = bus_iom_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_io_arb : directed self-checking bench for mem_io_arb         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_mem_io_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_iom, dbg_req, dbg_we, dbg_iom, bus_ready;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, bus_rdata;

  logic        cpu_ack, cpu_err, dbg_ack, dbg_err, bus_valid, bus_we, bus_iom, busy;
  logic [15:0] cpu_rdata, dbg_rdata, bus_addr, bus_wdata;

  logic        p_cpu_ack, p_cpu_err, p_dbg_ack, p_dbg_err, p_bus_valid, p_bus_we, p_bus_iom, p_busy;
  logic [15:0] p_cpu_rdata, p_dbg_rdata, p_bus_addr, p_bus_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_io_arb #(.AW(16), .DW(16), .WAIT_MAX(15), .PRIO_DBG(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_iom(cpu_iom), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_iom(dbg_iom), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_iom(bus_iom), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata), .busy(busy)
  );

  mem_io_arb #(.AW(16), .DW(16), .WAIT_MAX(15), .PRIO_DBG(1)) dut_prio (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_iom(cpu_iom), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(p_cpu_ack), .cpu_err(p_cpu_err), .cpu_rdata(p_cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_iom(dbg_iom), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(p_dbg_ack), .dbg_err(p_dbg_err), .dbg_rdata(p_dbg_rdata),
    .bus_valid(p_bus_valid), .bus_we(p_bus_we), .bus_iom(p_bus_iom), .bus_addr(p_bus_addr),
    .bus_wdata(p_bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata), .busy(p_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int      ng;
    int      grant [4];
    int      p_first;
    int      vcnt;
    bit      got;

    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_iom = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_iom = 0; dbg_addr = 0; dbg_wdata = 0;
    bus_ready = 0; bus_rdata = 0;

    // Reset state
    #12;
    check("reset_outputs",
          {cpu_ack, cpu_err, dbg_ack, dbg_err, bus_valid, bus_we, bus_iom, busy, bus_addr, bus_wdata},
          40'h0);
    check("reset_rdata", {cpu_rdata, dbg_rdata}, 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: single CPU read, zero wait
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    tick();
    check("t1_bus", {bus_valid, bus_we, bus_addr, busy}, {1'b1, 1'b0, 16'h0010, 1'b1});
    bus_ready = 1; bus_rdata = 16'hBEEF;
    tick();
    check("t1_ack", {cpu_ack, cpu_err, dbg_ack, bus_valid}, 4'b1000);
    check("t1_rdata", cpu_rdata, 16'hBEEF);
    cpu_req = 0; bus_ready = 0;
    tick();
    check("t1_done", {cpu_ack, busy}, 2'b00);

    // 2: tie, held requests; round-robin vs DBG priority instance
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0200;
    bus_ready = 1; bus_rdata = 16'h1234;
    ng = 0; p_first = 2;
    for (int i = 0; i < 20 && ng < 4; i++) begin
      tick();
      if (p_first == 2 && p_cpu_ack) p_first = 0;
      if (p_first == 2 && p_dbg_ack) p_first = 1;
      if (cpu_ack)      begin grant[ng] = 0; ng++; end
      else if (dbg_ack) begin grant[ng] = 1; ng++; end
    end
    cpu_req = 0; dbg_req = 0; bus_ready = 0;
    check("t2_grants", ng, 4);
    check("t2_order", {grant[0][1:0], grant[1][1:0], grant[2][1:0], grant[3][1:0]}, 8'b00_01_00_01);
    check("t2_prio_first", p_first, 1);
    tick(); tick();

    // 3: DBG IO write with 4 wait states
    dbg_req = 1; dbg_we = 1; dbg_iom = 1; dbg_addr = 16'h0003; dbg_wdata = 16'h00A5;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t3_bus_stable", {bus_valid, bus_we, bus_iom, bus_addr, bus_wdata},
            {1'b1, 1'b1, 1'b1, 16'h0003, 16'h00A5});
      if (i == 4) bus_ready = 1;
      tick();
    end
    check("t3_ack", {dbg_ack, dbg_err, cpu_ack, bus_valid}, 4'b1000);
    check("t3_rdata_kept", dbg_rdata, 16'h1234);
    dbg_req = 0; dbg_we = 0; dbg_iom = 0; bus_ready = 0;
    tick();
    check("t3_ack_once", {dbg_ack, busy}, 2'b00);

    // 4: timeout, then a clean transaction
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
    vcnt = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (bus_valid) vcnt++;
      if (cpu_ack) begin
        got = 1;
        check("t4_err", cpu_err, 1'b1);
        check("t4_rdata_kept", cpu_rdata, 16'h1234);
      end
    end
    check("t4_ack_seen", got, 1'b1);
    check("t4_valid_cycles", vcnt, 15);
    cpu_req = 0;
    tick();
    cpu_req = 1; bus_ready = 1; bus_rdata = 16'h5A5A;
    tick();
    tick();
    check("t4_next_ok", {cpu_ack, cpu_err}, 2'b10);
    check("t4_next_rdata", cpu_rdata, 16'h5A5A);
    cpu_req = 0; bus_ready = 0;
    tick();

    // 5: async reset in the middle of a bus wait
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0077;
    tick();
    check("t5_in_bus", bus_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_clear", {bus_valid, busy, cpu_ack, dbg_ack, bus_addr}, 20'h0);
    check("t5_rdata_clear", {cpu_rdata, dbg_rdata}, 32'h0);
    cpu_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    cpu_req = 1; cpu_addr = 16'h0100;
    dbg_req = 1; dbg_addr = 16'h0200;
    bus_ready = 1;
    tick();
    check("t5_tie_cpu_first", bus_addr, 16'h0100);
    tick();
    check("t5_tie_ack", {cpu_ack, dbg_ack}, 2'b10);
    cpu_req = 0; dbg_req = 0; bus_ready = 0;
    tick(); tick();

    // 6: bus_ready with nothing pending
    bus_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_idle", {busy, cpu_ack, dbg_ack, bus_valid}, 4'b0000);
    end
    bus_ready = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
